// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the fetch queue.
//   NOP_INSTR        : instruction presented to IF/ID when the queue is empty
//   DEFAULT_DEPTH    : default number of instruction entries
//   DEFAULT_RESET_PC : default first fetch address after reset
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int unsigned DEFAULT_DEPTH    = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Generic synchronous FIFO with push/pop/clear and occupancy count.
// Ports:
//   clk_i, rst_ni        : clock, async active-low reset
//   push_i, wdata_i      : write request and data (ignored when full unless popping)
//   pop_i                : read request (ignored when empty)
//   clear_i              : flush all entries; overrides push and pop
//   rdata_o              : head entry (undefined when empty)
//   full_o, empty_o      : status flags
//   count_o              : number of entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO can still accept a write in the same cycle its head leaves.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between instruction memory and the IF/ID stage.
// Issues word fetches under a credit rule (queued + outstanding < DEPTH),
// tags each request with its address, pairs in-order responses with tags,
// and presents the oldest instruction to IF/ID. A redirect flushes both
// queues and discards responses still owed for the old path.
// Ports:
//   clk_i, rst_ni                  : clock, async active-low reset
//   redirect_i, redirect_pc_i      : taken branch/jump and its target
//   imem_req_valid_o/ready_i/addr_o: fetch request handshake
//   imem_resp_valid_i/data_i       : in-order response, latency >= 1
//   id_valid_o, id_ready_i         : head handshake towards IF/ID
//   id_instrucao_o, id_pc_o,
//   id_pc_plus4_o                  : head instruction, its address, address + 4
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instrucao_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    // Stale responses can accumulate across back-to-back redirects, so the
    // drop counter is sized for two full windows rather than one.
    localparam int unsigned DW = $clog2(2 * DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [DW-1:0] drop_q, drop_d;
    logic [31:0]   last_pc_q, last_pc_d;

    logic [31:0]   tag_head;
    logic          tag_full, tag_empty;
    logic [CW-1:0] tag_cnt;

    logic [63:0]   iq_head;
    logic          iq_full, iq_empty;
    logic [CW-1:0] iq_cnt;

    logic          credit_ok;
    logic          req_fire;
    logic          resp_live;
    logic          resp_keep;
    logic          resp_drop;
    logic          id_pop;
    logic [DW:0]   owed_sum;

    // The tag queue holds exactly the kept requests still awaiting data,
    // so its count is the outstanding-request count.
    assign credit_ok = ((CW+1)'(iq_cnt) + (CW+1)'(tag_cnt)) < (CW+1)'(DEPTH);

    // Gated by rst_ni so no request is offered while reset is held.
    assign imem_req_valid_o = rst_ni & ~redirect_i & credit_ok & ~tag_full & ~iq_full;
    assign imem_req_addr_o  = word_align(fetch_pc_q);
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;

    assign resp_live = imem_resp_valid_i & ~redirect_i;
    assign resp_drop = resp_live & (drop_q != '0);
    assign resp_keep = resp_live & (drop_q == '0) & ~tag_empty;

    assign id_pop = ~iq_empty & id_ready_i & ~redirect_i;

    // Everything still owed by memory at the redirect: earlier drops plus
    // the kept outstanding requests, less the one answered this cycle.
    assign owed_sum = (DW+1)'(drop_q) + (DW+1)'(tag_cnt);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        last_pc_d  = last_pc_q;

        if (!iq_empty) last_pc_d = iq_head[63:32];

        if (redirect_i) begin
            fetch_pc_d = word_align(redirect_pc_i);
            if (imem_resp_valid_i && owed_sum != '0) begin
                drop_d = DW'(owed_sum - (DW+1)'(1));
            end else begin
                drop_d = DW'(owed_sum);
            end
        end else begin
            if (req_fire)  fetch_pc_d = fetch_pc_q + 32'd4;
            if (resp_drop) drop_d     = drop_q - DW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
            last_pc_q  <= 32'h0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            last_pc_q  <= last_pc_d;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_fire),
        .wdata_i (imem_req_addr_o),
        .pop_i   (resp_keep),
        .clear_i (redirect_i),
        .rdata_o (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_cnt)
    );

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (resp_keep),
        .wdata_i ({tag_head, imem_resp_data_i}),
        .pop_i   (id_pop),
        .clear_i (redirect_i),
        .rdata_o (iq_head),
        .full_o  (iq_full),
        .empty_o (iq_empty),
        .count_o (iq_cnt)
    );

    assign id_valid_o     = ~iq_empty;
    assign id_instrucao_o = iq_empty ? NOP_INSTR : iq_head[31:0];
    assign id_pc_o        = iq_empty ? last_pc_q : iq_head[63:32];
    assign id_pc_plus4_o  = id_pc_o + 32'd4;

endmodule
